// File: rtl/loop_issue_pkg.sv
// Shared types for the loop issue generator: FSM state encoding and default width.
// Pure declarations; no logic, no latency, no flow control.
package loop_issue_pkg;

  localparam int ISSUE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } issue_state_t;

endpackage

// File: rtl/loop_issue_generator_interval_timer.sv
// Loadable down-counter that flags expire while its count is exactly 1.
// Load takes effect on the next clock; en decrements; no backpressure.
module interval_timer
  import loop_issue_pkg::*;
#(
  parameter int W = ISSUE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == W'(1));

endmodule

// File: rtl/loop_issue_generator.sv
// Issues one happening pulse every II clocks for trip_count iterations, then pulses done.
// First pulse one clock after an accepted start; start is ignored while busy, abort cancels.
module loop_issue_generator
  import loop_issue_pkg::*;
#(
  parameter int W = ISSUE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] trip_count,
  input  logic [W-1:0] ii,
  input  logic         abort,
  output logic         happening,
  output logic [W-1:0] iter_idx,
  output logic         first,
  output logic         last,
  output logic         busy,
  output logic         done
);

  issue_state_t state_q, state_d;
  logic [W-1:0] iter_q, iter_d;
  logic [W-1:0] trip_m1_q, trip_m1_d;
  logic [W-1:0] ii_eff_q, ii_eff_d;
  logic         happening_q, first_q, last_q, busy_q, done_q;
  logic         accept;
  logic         tmr_load;
  logic         tmr_en;
  logic         tmr_expire;
  logic [W-1:0] tmr_load_val;

  assign accept       = start && !abort;
  assign tmr_en       = (state_q == WAIT);
  assign tmr_load_val = ii_eff_q - W'(1);

  interval_timer #(.W(W)) u_interval_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    trip_m1_d = trip_m1_q;
    ii_eff_d  = ii_eff_q;
    tmr_load  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (trip_count == '0) begin
            state_d = DONE;
          end else begin
            // Storing trip-1 keeps the last-iteration compare free of overflow at trip=2^W-1.
            trip_m1_d = trip_count - W'(1);
            ii_eff_d  = (ii == '0) ? W'(1) : ii;
            iter_d    = '0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (iter_q == trip_m1_q) begin
          state_d = DONE;
        end else if (ii_eff_q == W'(1)) begin
          iter_d = iter_q + W'(1);
        end else begin
          tmr_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_expire) begin
          iter_d  = iter_q + W'(1);
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      trip_m1_q   <= '0;
      ii_eff_q    <= '0;
      happening_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      trip_m1_q   <= trip_m1_d;
      ii_eff_q    <= ii_eff_d;
      happening_q <= (state_d == ISSUE);
      first_q     <= (state_d == ISSUE) && (iter_d == '0);
      last_q      <= (state_d == ISSUE) && (iter_d == trip_m1_d);
      busy_q      <= (state_d == ISSUE) || (state_d == WAIT);
      done_q      <= (state_d == DONE);
    end
  end

  assign happening = happening_q;
  assign iter_idx  = iter_q;
  assign first     = first_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/loop_issue_generator.md
# loop_issue_generator

Generates the iteration-issue pulse train for a pipelined loop: after an accepted start it emits `happening` once every II clocks, for trip_count iterations, then pulses `done`. It is the signal producer that the counting/observer blocks (clocks-since-signal, condition-at-last-signal) monitor. It sits between the loop controller and the datapath stage enables.

## Interface
- `W`, 32, width of trip_count, ii and iter_idx
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request a loop run; sampled only when `busy`=0
- `trip_count`  in  W  iteration count; latched when start is accepted
- `ii`  in  W  initiation interval in clocks; latched when start is accepted; 0 is treated as 1
- `abort`  in  1  cancel the current run
- `happening`  out  1  one-cycle issue pulse per iteration
- `iter_idx`  out  W  index of the current or most recent iteration, 0-based
- `first`  out  1  `happening` for iteration 0
- `last`  out  1  `happening` for iteration trip_count-1
- `busy`  out  1  a run is in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: no run in progress.
  - ISSUE: the cycle in which `happening` fires.
  - WAIT: waiting out the II interval.
  - DONE: the one-cycle completion state.
- Reset (async, active-low): state=IDLE; all outputs 0; `iter_idx`=0; internal counters=0.
- Start is accepted when `start`=1, `busy`=0 and `abort`=0.
  - trip_count=0: go to DONE; no `happening`.
  - Otherwise: latch the values, set ii_eff=max(ii,1), clear the iteration counter, go to ISSUE.
- ISSUE:
  - `happening`=1.
  - `iter_idx` = iteration counter.
  - `first` = (iteration counter==0).
  - `last` = (iteration counter==trip-1).
  - Next state:
    - If last: DONE.
    - Else if ii_eff=1: ISSUE, counter+1.
    - Else: WAIT, load the interval counter with ii_eff-1.
- WAIT: decrement the interval counter; when it reaches 1, go to ISSUE with counter+1.
- DONE:
  - `done`=1 and `busy`=0.
  - `iter_idx` holds its last value.
  - Start is accepted in this cycle, which allows back-to-back runs.
  - Next state is IDLE, or the accepted run's next state.
- `busy`=1 in ISSUE and WAIT only.
- Abort:
  - `abort`=1 in ISSUE or WAIT: next state is IDLE; no `done`; `happening` in the abort cycle still fires if the state is ISSUE.
  - Abort has priority over a simultaneous start.
- Arithmetic:
  - All counters are W-bit unsigned.
  - Compare trip-1 only when trip≥1.
  - trip=2^W−1 and ii=2^W−1 must work without overflow.
  - The counter never wraps because the run ends at trip-1.
- `start` while `busy`=1 is ignored; it is not queued.
- `trip_count` and `ii` changes mid-run have no effect.

## Timing
- Start accepted in cycle c: `happening` occurs in cycles c+1+k·ii_eff, for k=0..N−1.
- `done` occurs in cycle c+1+(N−1)·ii_eff+1.
- N=0: `done` in cycle c+1; `busy` stays 0.
- `busy` is high from c+1 through the last `happening` cycle, inclusive.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Reset asserted mid-run: outputs drop to 0 asynchronously; no `done`.
- After reset deasserts, the first possible accept is on the first clock edge.

## Structure
- Shared package `loop_issue_pkg`:
  - state enum `issue_state_t` {IDLE, ISSUE, WAIT, DONE};
  - default width constant `ISSUE_W`=32.
- One sub-module, `interval_timer`:
  - W-bit loadable down-counter;
  - inputs: load, load_val, en;
  - output: expire when the count reaches 1.
  - The top FSM owns the iteration counter.

## Test plan
- trip=4, ii=3, start in cycle 10:
  - `happening` in cycles 11, 14, 17, 20;
  - `first` in cycle 11, `last` in cycle 20;
  - `iter_idx` = 0, 1, 2, 3;
  - `done` in cycle 21; `busy` high in cycles 11–20.
- ii=0 and ii=1, trip=3, start in cycle 5:
  - `happening` in cycles 6, 7, 8;
  - `done` in cycle 9;
  - both ii values give identical traces.
- trip=0: `done` one cycle after start; no `happening`; `busy` never high. Also drive `start` during `busy` in a trip=2, ii=4 run: the extra start is ignored.
- Back-to-back runs: first run trip=2, ii=2; second start is high during its `done` cycle with trip=1. The second run's `happening` comes one cycle after that `done`.
- Abort during WAIT of trip=5, ii=4 after 2 issues:
  - `busy` goes low the next cycle; no `done`; no further `happening`.
  - Abort in the same cycle as a start while idle: the start is not accepted.
- Reset mid-run (`rst` low for 1 cycle between edges): outputs clear immediately and no `done` is issued. Then cross-check a fresh trip=6, ii=5 run against the clocks-since-signal observer: its count equals 5 at every `happening` after the first.
